decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 48 ++++
 rtl/decode_stage.sv | 335 +++++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle bus between fetch, decode_stage and execute.
//   master : the side that offers instructions, accepts bundles and drives flush
//   slave  : decode_stage itself
// Signals:
//   flush                       discard every instruction held in the stage
//   in_valid/in_ready/in_instr/in_pc  fetch-side handshake and payload
//   out_valid/out_ready         execute-side handshake
//   out_pc, rs1, rs2, rd, imm, alu_op, src2_imm, mem_ren, mem_wen,
//   rw_type, b_ins, j_ins, u_ins, reg_wen, illegal   decoded bundle
interface decode_stage_if #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned ALUOP_W = 5
);
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        in_instr;
   logic [PC_W-1:0]    in_pc;
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [4:0]         rs1;
   logic [4:0]         rs2;
   logic [4:0]         rd;
   logic [31:0]        imm;
   logic [ALUOP_W-1:0] alu_op;
   logic               src2_imm;
   logic               mem_ren;
   logic               mem_wen;
   logic [3:0]         rw_type;
   logic [5:0]         b_ins;
   logic [1:0]         j_ins;
   logic [1:0]         u_ins;
   logic               reg_wen;
   logic               illegal;

   modport master (
      output flush, in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_op, src2_imm,
             mem_ren, mem_wen, rw_type, b_ins, j_ins, u_ins, reg_wen, illegal
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_op, src2_imm,
             mem_ren, mem_wen, rw_type, b_ins, j_ins, u_ins, reg_wen, illegal
   );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage with a registered 2-entry skid buffer.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   bus      decode_stage_if.slave: flush, fetch handshake (in_*),
//            execute handshake (out_valid/out_ready) and decoded bundle
// Parameters:
//   PC_W     program-counter width carried with each instruction
//   ALUOP_W  alu_op width (>= 5)
// Optional feature macro:
//   DECODE_STAGE_M_EXT_EN  decode the M extension (alu_op 10..17); when
//                          undefined those encodings are illegal.
// FENCE, ECALL, EBREAK and CSR encodings are reported as illegal.
module decode_stage #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned ALUOP_W = 5
) (
   input  logic          clk,
   input  logic          rst,
   decode_stage_if.slave bus
);

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned REG_W   = 5;

   generate
      if (ALUOP_W < 5) begin : g_bad_aluop_w
         $error("decode_stage: ALUOP_W must be at least 5");
      end
   endgenerate

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(8);
   localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(9);
`ifdef DECODE_STAGE_M_EXT_EN
   localparam logic [6:0]         F7_MULDIV = 7'h01;
   localparam logic [ALUOP_W-1:0] ALU_MUL   = ALUOP_W'(10);
`endif

   // Decoded bundle held in each skid slot
   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [REG_W-1:0]   rs1;
      logic [REG_W-1:0]   rs2;
      logic [REG_W-1:0]   rd;
      logic [INSTR_W-1:0] imm;
      logic [ALUOP_W-1:0] alu_op;
      logic               src2_imm;
      logic               mem_ren;
      logic               mem_wen;
      logic [3:0]         rw_type;
      logic [5:0]         b_ins;
      logic [1:0]         j_ins;
      logic [1:0]         u_ins;
      logic               reg_wen;
      logic               illegal;
   } dec_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   logic [INSTR_W-1:0] instr;
   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic [INSTR_W-1:0] imm_i;
   logic [INSTR_W-1:0] imm_s;
   logic [INSTR_W-1:0] imm_b;
   logic [INSTR_W-1:0] imm_u;
   logic [INSTR_W-1:0] imm_j;

   assign instr  = bus.in_instr;
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Sign-extended immediates of each instruction format
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   dec_t dec_c;
   logic dec_wr_c;
   logic dec_ill_c;

   // Combinational decode of the instruction currently offered by fetch
   always_comb begin
      dec_c          = '0;
      dec_wr_c       = 1'b0;
      dec_ill_c      = 1'b0;
      dec_c.pc       = bus.in_pc;
      dec_c.rs1      = instr[19:15];
      dec_c.rs2      = instr[24:20];
      dec_c.rd       = instr[11:7];
      dec_c.src2_imm = 1'b1;
      dec_c.alu_op   = ALU_ADD;

      case (opcode)
         OPC_LUI: begin
            dec_c.imm   = imm_u;
            dec_c.u_ins = 2'b10;
            dec_wr_c    = 1'b1;
         end
         OPC_AUIPC: begin
            dec_c.imm   = imm_u;
            dec_c.u_ins = 2'b01;
            dec_wr_c    = 1'b1;
         end
         OPC_JAL: begin
            dec_c.imm   = imm_j;
            dec_c.j_ins = 2'b10;
            dec_wr_c    = 1'b1;
         end
         OPC_JALR: begin
            dec_c.imm   = imm_i;
            dec_c.j_ins = 2'b01;
            dec_wr_c    = 1'b1;
            dec_ill_c   = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            dec_c.imm      = imm_b;
            dec_c.alu_op   = ALU_SUB;
            dec_c.src2_imm = 1'b0;
            // b_ins bit order: {beq, bne, bge, blt, bgeu, bltu}
            case (funct3)
               3'b000:  dec_c.b_ins = 6'b100000;
               3'b001:  dec_c.b_ins = 6'b010000;
               3'b100:  dec_c.b_ins = 6'b000100;
               3'b101:  dec_c.b_ins = 6'b001000;
               3'b110:  dec_c.b_ins = 6'b000001;
               3'b111:  dec_c.b_ins = 6'b000010;
               default: dec_ill_c   = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec_c.imm     = imm_i;
            dec_c.mem_ren = 1'b1;
            dec_wr_c      = 1'b1;
            // rw_type bit order: {unsigned, word, half, byte}
            case (funct3)
               3'b000:  dec_c.rw_type = 4'b0001;
               3'b001:  dec_c.rw_type = 4'b0010;
               3'b010:  dec_c.rw_type = 4'b0100;
               3'b100:  dec_c.rw_type = 4'b1001;
               3'b101:  dec_c.rw_type = 4'b1010;
               default: dec_ill_c     = 1'b1;
            endcase
         end
         OPC_STORE: begin
            dec_c.imm     = imm_s;
            dec_c.mem_wen = 1'b1;
            case (funct3)
               3'b000:  dec_c.rw_type = 4'b0001;
               3'b001:  dec_c.rw_type = 4'b0010;
               3'b010:  dec_c.rw_type = 4'b0100;
               default: dec_ill_c     = 1'b1;
            endcase
         end
         OPC_OPIMM: begin
            dec_c.imm = imm_i;
            dec_wr_c  = 1'b1;
            case (funct3)
               3'b000:  dec_c.alu_op = ALU_ADD;
               3'b010:  dec_c.alu_op = ALU_SLT;
               3'b011:  dec_c.alu_op = ALU_SLTU;
               3'b100:  dec_c.alu_op = ALU_XOR;
               3'b110:  dec_c.alu_op = ALU_OR;
               3'b111:  dec_c.alu_op = ALU_AND;
               3'b001: begin
                  dec_c.alu_op = ALU_SLL;
                  dec_ill_c    = (funct7 != F7_BASE);
               end
               default: begin
                  // funct3 101: shamt upper bits select SRLI / SRAI
                  if (funct7 == F7_BASE) begin
                     dec_c.alu_op = ALU_SRL;
                  end else if (funct7 == F7_ALT) begin
                     dec_c.alu_op = ALU_SRA;
                  end else begin
                     dec_ill_c = 1'b1;
                  end
               end
            endcase
         end
         OPC_OP: begin
            dec_c.src2_imm = 1'b0;
            dec_wr_c       = 1'b1;
            case (funct7)
               F7_BASE: begin
                  case (funct3)
                     3'b000:  dec_c.alu_op = ALU_ADD;
                     3'b001:  dec_c.alu_op = ALU_SLL;
                     3'b010:  dec_c.alu_op = ALU_SLT;
                     3'b011:  dec_c.alu_op = ALU_SLTU;
                     3'b100:  dec_c.alu_op = ALU_XOR;
                     3'b101:  dec_c.alu_op = ALU_SRL;
                     3'b110:  dec_c.alu_op = ALU_OR;
                     default: dec_c.alu_op = ALU_AND;
                  endcase
               end
               F7_ALT: begin
                  case (funct3)
                     3'b000:  dec_c.alu_op = ALU_SUB;
                     3'b101:  dec_c.alu_op = ALU_SRA;
                     default: dec_ill_c    = 1'b1;
                  endcase
               end
`ifdef DECODE_STAGE_M_EXT_EN
               // MUL..REMU are contiguous codes in funct3 order
               F7_MULDIV: dec_c.alu_op = ALU_MUL + ALUOP_W'(funct3);
`endif
               default: dec_ill_c = 1'b1;
            endcase
         end
         default: dec_ill_c = 1'b1;
      endcase

      dec_c.illegal = dec_ill_c;
      dec_c.reg_wen = dec_wr_c & ~dec_ill_c & (dec_c.rd != 5'd0);
      // Illegal instructions must not touch memory or redirect control flow
      if (dec_ill_c) begin
         dec_c.mem_ren = 1'b0;
         dec_c.mem_wen = 1'b0;
         dec_c.b_ins   = 6'b0;
         dec_c.j_ins   = 2'b0;
         dec_c.u_ins   = 2'b0;
         dec_c.rw_type = 4'b0;
      end
   end

   state_t state;
   dec_t   slot0;      // oldest entry, drives out_*
   dec_t   slot1;      // second entry, only meaningful in S_FULL
   logic   in_ready_r;
   logic   out_valid_r;
   logic   accept_c;
   logic   drain_c;

   assign accept_c = bus.in_valid & in_ready_r;
   assign drain_c  = out_valid_r & bus.out_ready;

   // Skid-buffer control; in_ready/out_valid are registered alongside state
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         slot0       <= '0;
         slot1       <= '0;
      end else if (bus.flush) begin
         state       <= S_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state)
            S_EMPTY: begin
               if (accept_c) begin
                  slot0       <= dec_c;
                  state       <= S_ONE;
                  out_valid_r <= 1'b1;
               end
            end
            S_ONE: begin
               if (accept_c && !drain_c) begin
                  slot1      <= dec_c;
                  state      <= S_FULL;
                  in_ready_r <= 1'b0;
               end else if (accept_c && drain_c) begin
                  slot0 <= dec_c;
               end else if (drain_c) begin
                  state       <= S_EMPTY;
                  out_valid_r <= 1'b0;
               end
            end
            S_FULL: begin
               // in_ready is low here, so only a drain can occur
               if (drain_c) begin
                  slot0      <= slot1;
                  state      <= S_ONE;
                  in_ready_r <= 1'b1;
               end
            end
            default: begin
               state       <= S_EMPTY;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_pc    = slot0.pc;
   assign bus.rs1       = slot0.rs1;
   assign bus.rs2       = slot0.rs2;
   assign bus.rd        = slot0.rd;
   assign bus.imm       = slot0.imm;
   assign bus.alu_op    = slot0.alu_op;
   assign bus.src2_imm  = slot0.src2_imm;
   assign bus.mem_ren   = slot0.mem_ren;
   assign bus.mem_wen   = slot0.mem_wen;
   assign bus.rw_type   = slot0.rw_type;
   assign bus.b_ins     = slot0.b_ins;
   assign bus.j_ins     = slot0.j_ins;
   assign bus.u_ins     = slot0.u_ins;
   assign bus.reg_wen   = slot0.reg_wen;
   assign bus.illegal   = slot0.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized
// traffic compared against a queue-based occupancy model and a
// table-driven RV32I reference decoder.
module tb_decode_stage;

   logic clk;
   logic rst;

   decode_stage_if #(.PC_W(32), .ALUOP_W(5)) bus ();

   decode_stage #(.PC_W(32), .ALUOP_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference decoder tables indexed by funct3
   int       r_tab  [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
   bit [5:0] b_tab  [8] = '{6'b100000, 6'b010000, 6'b0, 6'b0, 6'b000100, 6'b001000, 6'b000001, 6'b000010};
   bit [3:0] ld_tab [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0, 4'b1001, 4'b1010, 4'b0, 4'b0};
   bit [6:0] op_pool [12] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h33, 7'h0f, 7'h73};

   typedef struct {
      bit        ill;
      int        alu;
      bit        s2i;
      bit        mr;
      bit        mw;
      bit [3:0]  rw;
      bit [5:0]  b;
      bit [1:0]  j;
      bit [1:0]  u;
      bit        rwen;
      bit [31:0] imm;
      bit        chk_imm;
      bit        chk_alu;
      bit        chk_rs1;
      bit        chk_rs2;
   } ref_t;

   function automatic ref_t ref_decode(input bit [31:0] i);
      ref_t     r;
      bit [6:0] opc   = i[6:0];
      int       f3    = int'(i[14:12]);
      bit [6:0] f7    = i[31:25];
      int       sx    = $signed(i);
      bit       wr    = 1'b0;
      int       imm_i = sx >>> 20;
      int       imm_s = ((sx >>> 25) * 32) + int'(i[11:7]);
      int       imm_b = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      int       imm_u = int'(i & 32'hFFFFF000);
      int       imm_j = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      r = '{default: 0};
      r.s2i = 1'b1;
      case (opc)
         7'h37: begin r.u = 2'b10; r.imm = 32'(imm_u); r.chk_imm = 1; wr = 1; end
         7'h17: begin r.u = 2'b01; r.imm = 32'(imm_u); r.chk_imm = 1; r.chk_alu = 1; wr = 1; end
         7'h6f: begin r.j = 2'b10; r.imm = 32'(imm_j); r.chk_imm = 1; r.chk_alu = 1; wr = 1; end
         7'h67: begin
            r.j = 2'b01; r.imm = 32'(imm_i); r.chk_imm = 1; r.chk_alu = 1; r.chk_rs1 = 1; wr = 1;
            r.ill = (f3 != 0);
         end
         7'h63: begin
            r.b = b_tab[f3]; r.ill = (b_tab[f3] == 0); r.alu = 1; r.s2i = 0;
            r.imm = 32'(imm_b); r.chk_imm = 1; r.chk_alu = 1; r.chk_rs1 = 1; r.chk_rs2 = 1;
         end
         7'h03: begin
            r.rw = ld_tab[f3]; r.ill = (ld_tab[f3] == 0); r.mr = 1;
            r.imm = 32'(imm_i); r.chk_imm = 1; r.chk_alu = 1; r.chk_rs1 = 1; wr = 1;
         end
         7'h23: begin
            r.ill = (f3 > 2); r.rw = (f3 <= 2) ? 4'(1 << f3) : 4'b0; r.mw = 1;
            r.imm = 32'(imm_s); r.chk_imm = 1; r.chk_alu = 1; r.chk_rs1 = 1; r.chk_rs2 = 1;
         end
         7'h13: begin
            r.imm = 32'(imm_i); r.chk_imm = 1; r.chk_alu = 1; r.chk_rs1 = 1; wr = 1;
            r.alu = r_tab[f3];
            if (f3 == 1) r.ill = (f7 != 7'h00);
            if (f3 == 5) begin
               if (f7 == 7'h20) r.alu = 7;
               else if (f7 != 7'h00) r.ill = 1;
            end
         end
         7'h33: begin
            r.s2i = 0; r.chk_alu = 1; r.chk_rs1 = 1; r.chk_rs2 = 1; wr = 1;
            if (f7 == 7'h00) r.alu = r_tab[f3];
            else if (f7 == 7'h20 && f3 == 0) r.alu = 1;
            else if (f7 == 7'h20 && f3 == 5) r.alu = 7;
`ifdef DECODE_STAGE_M_EXT_EN
            else if (f7 == 7'h01) r.alu = 10 + f3;
`endif
            else r.ill = 1;
         end
         default: r.ill = 1;
      endcase
      r.rwen = wr && !r.ill && (i[11:7] != 5'd0);
      if (r.ill) begin
         r.mr = 0; r.mw = 0; r.b = 0; r.j = 0;
      end
      return r;
   endfunction

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } item_t;

   item_t q[$];
   bit    checks_on = 1'b0;

   task automatic compare_bundle(input item_t it);
      ref_t r = ref_decode(it.instr);
      check_eq("illegal", 64'(bus.illegal), 64'(r.ill));
      check_eq("mem_ren", 64'(bus.mem_ren), 64'(r.mr));
      check_eq("mem_wen", 64'(bus.mem_wen), 64'(r.mw));
      check_eq("b_ins",   64'(bus.b_ins),   64'(r.b));
      check_eq("j_ins",   64'(bus.j_ins),   64'(r.j));
      check_eq("reg_wen", 64'(bus.reg_wen), 64'(r.rwen));
      check_eq("out_pc",  64'(bus.out_pc),  64'(it.pc));
      check_eq("rd",      64'(bus.rd),      64'(it.instr[11:7]));
      if (!r.ill) begin
         check_eq("src2_imm", 64'(bus.src2_imm), 64'(r.s2i));
         check_eq("rw_type",  64'(bus.rw_type),  64'(r.rw));
         check_eq("u_ins",    64'(bus.u_ins),    64'(r.u));
         if (r.chk_alu) check_eq("alu_op", 64'(bus.alu_op), 64'(r.alu));
         if (r.chk_imm) check_eq("imm",    64'(bus.imm),    64'(r.imm));
         if (r.chk_rs1) check_eq("rs1",    64'(bus.rs1),    64'(it.instr[19:15]));
         if (r.chk_rs2) check_eq("rs2",    64'(bus.rs2),    64'(it.instr[24:20]));
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance.
   // Called and returns at a falling edge.
   task automatic cycle(input bit rs, input bit fl, input bit iv,
                        input logic [31:0] ins, input logic [31:0] pc, input bit ordy);
      bit acc;
      bit drn;
      rst           = rs;
      bus.flush     = fl;
      bus.in_valid  = iv;
      bus.in_instr  = ins;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
      if (checks_on) begin
         check_eq("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
         check_eq("in_ready",  64'(bus.in_ready),  64'(q.size() != 2));
         if (bus.out_valid === 1'b1 && q.size() != 0) compare_bundle(q[0]);
      end
      acc = iv && (q.size() != 2);
      drn = ordy && (q.size() != 0);
      if (rs || fl) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back('{ins, pc});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] i = $urandom;
      int          k = $urandom_range(0, 12);
      int          s = $urandom_range(0, 3);
      if (k < 12) i[6:0] = op_pool[k];
      if (s == 0) i[31:25] = 7'h00;
      else if (s == 1) i[31:25] = 7'h20;
      else if (s == 2) i[31:25] = 7'h01;
      return i;
   endfunction

   initial begin
      rst           = 1'b1;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'h0;
      bus.in_pc     = 32'h0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks_on = 1'b1;

      // Reset state: empty, ready, payload cleared
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_in_ready",  64'(bus.in_ready),  64'd1);
      check_eq("rst_out_pc",    64'(bus.out_pc),    64'd0);
      check_eq("rst_imm",       64'(bus.imm),       64'd0);
      check_eq("rst_alu_op",    64'(bus.alu_op),    64'd0);
      check_eq("rst_reg_wen",   64'(bus.reg_wen),   64'd0);
      check_eq("rst_illegal",   64'(bus.illegal),   64'd0);
      cycle(1, 0, 0, 32'h0, 32'h0, 0);

      // addi x1,x0,5
      cycle(0, 0, 1, 32'h00500093, 32'h100, 1);
      check_eq("addi_out_valid", 64'(bus.out_valid), 64'd1);
      check_eq("addi_rd",        64'(bus.rd),        64'd1);
      check_eq("addi_rs1",       64'(bus.rs1),       64'd0);
      check_eq("addi_imm",       64'(bus.imm),       64'd5);
      check_eq("addi_alu_op",    64'(bus.alu_op),    64'd0);
      check_eq("addi_src2_imm",  64'(bus.src2_imm),  64'd1);
      check_eq("addi_reg_wen",   64'(bus.reg_wen),   64'd1);
      check_eq("addi_illegal",   64'(bus.illegal),   64'd0);

      // beq x1,x2,-4
      cycle(0, 0, 1, 32'hFE208EE3, 32'h104, 1);
      check_eq("beq_imm",      64'(bus.imm),      64'h0000_0000_FFFF_FFFC);
      check_eq("beq_b_ins",    64'(bus.b_ins),    64'b100000);
      check_eq("beq_alu_op",   64'(bus.alu_op),   64'd1);
      check_eq("beq_src2_imm", 64'(bus.src2_imm), 64'd0);
      check_eq("beq_reg_wen",  64'(bus.reg_wen),  64'd0);

      // mul x3,x1,x2
      cycle(0, 0, 1, 32'h022081B3, 32'h108, 1);
`ifdef DECODE_STAGE_M_EXT_EN
      check_eq("mul_alu_op",  64'(bus.alu_op),  64'd10);
      check_eq("mul_reg_wen", 64'(bus.reg_wen), 64'd1);
      check_eq("mul_illegal", 64'(bus.illegal), 64'd0);
`else
      check_eq("mul_illegal", 64'(bus.illegal), 64'd1);
      check_eq("mul_reg_wen", 64'(bus.reg_wen), 64'd0);
`endif

      // All-zero word and addi x0,x0,1
      cycle(0, 0, 1, 32'h00000000, 32'h10C, 1);
      check_eq("zero_illegal", 64'(bus.illegal), 64'd1);
      check_eq("zero_mem_ren", 64'(bus.mem_ren), 64'd0);
      cycle(0, 0, 1, 32'h00100013, 32'h110, 1);
      check_eq("nop_illegal", 64'(bus.illegal), 64'd0);
      check_eq("nop_reg_wen", 64'(bus.reg_wen), 64'd0);
      cycle(0, 0, 0, 32'h0, 32'h0, 1);
      check_eq("drained_out_valid", 64'(bus.out_valid), 64'd0);

      // Two accepted while execute stalls, then released in order
      cycle(0, 0, 1, 32'h00A00113, 32'h200, 0);
      cycle(0, 0, 1, 32'h01400193, 32'h204, 0);
      check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
      cycle(0, 0, 1, 32'h01E00213, 32'h208, 0);
      cycle(0, 0, 0, 32'h0, 32'h0, 1);
      check_eq("release_pc2", 64'(bus.out_pc), 64'h204);
      cycle(0, 0, 0, 32'h0, 32'h0, 1);
      check_eq("release_empty", 64'(bus.out_valid), 64'd0);

      // Flush a full stage while another instruction is offered
      cycle(0, 0, 1, 32'h00500293, 32'h300, 0);
      cycle(0, 0, 1, 32'h00600313, 32'h304, 0);
      cycle(0, 1, 1, 32'h00700393, 32'h308, 0);
      check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("flush_in_ready",  64'(bus.in_ready),  64'd1);
      cycle(0, 0, 0, 32'h0, 32'h0, 1);

      // Back-to-back streaming without bubbles
      for (int n = 0; n < 8; n++) begin
         cycle(0, 0, 1, rand_instr(), $urandom, 1);
         check_eq("stream_out_valid", 64'(bus.out_valid), 64'd1);
         check_eq("stream_in_ready",  64'(bus.in_ready),  64'd1);
      end
      cycle(0, 0, 0, 32'h0, 32'h0, 1);

      // Reset in the middle of a transfer, with flush also asserted
      cycle(0, 0, 1, 32'h00100413, 32'h400, 0);
      cycle(0, 0, 1, 32'h00200493, 32'h404, 0);
      cycle(1, 1, 1, 32'h00300513, 32'h408, 0);
      check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("midrst_in_ready",  64'(bus.in_ready),  64'd1);
      check_eq("midrst_out_pc",    64'(bus.out_pc),    64'd0);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         cycle(($urandom_range(0, 299) == 0),
               ($urandom_range(0, 49) == 0),
               ($urandom_range(0, 9) < 7),
               rand_instr(), $urandom,
               ($urandom_range(0, 9) < 6));
      end
      cycle(0, 0, 0, 32'h0, 32'h0, 1);
      cycle(0, 0, 0, 32'h0, 32'h0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
